// File: rtl/entropy_pool.sv
// entropy_pool: decimates raw entropy, runs a repetition health test,
// folds samples into bytes and buffers them in a small FWFT FIFO.
module entropy_pool #(
  parameter int SAMPLE_DIV = 16,
  parameter int FOLD       = 4,
  parameter int REP_LIMIT  = 8,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_dat,
  output logic       fault
);

  localparam int DW    = $clog2(SAMPLE_DIV);
  localparam int FW    = $clog2(FOLD + 1);
  localparam int RW    = $clog2(REP_LIMIT + 1);
  localparam int PW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]    r_raw_q;
  logic [DW-1:0] r_div;
  logic [RW-1:0] r_rep;
  logic [7:0]    r_last;
  logic [7:0]    r_acc;
  logic [FW-1:0] r_fold;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [7:0]    r_mem [DEPTH];
  logic          r_fault;

  logic          w_strobe;
  logic          w_live;
  logic [RW-1:0] w_rep_nxt;
  logic          w_trip;
  logic [7:0]    w_acc_nxt;
  logic          w_fold_done;
  logic          w_push;
  logic [PW-1:0] w_cnt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;

  assign w_strobe    = (r_div == DW'(SAMPLE_DIV - 1));
  assign w_live      = w_strobe && !r_fault;
  assign w_acc_nxt   = {r_acc[6:0], r_acc[7]} ^ r_raw_q;
  assign w_fold_done = (r_fold == FW'(FOLD - 1));
  assign w_trip      = w_live && (w_rep_nxt == RW'(REP_LIMIT));
  assign w_push      = w_live && w_fold_done && !w_trip;

  assign w_cnt   = r_wr - r_rd;
  assign w_empty = (w_cnt == '0);
  assign w_full  = w_cnt[FIFO_AW];
  assign w_pop   = out_valid && out_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);

  assign out_valid = !w_empty && !r_fault;
  assign out_dat   = out_valid ? r_mem[r_rd[FIFO_AW-1:0]] : 8'h00;
  assign fault     = r_fault;

  // Next repetition count; zero marks "no sample seen since reset".
  always_comb begin
    w_rep_nxt = RW'(1);
    if (r_rep != '0 && r_raw_q == r_last) begin
      if (r_rep == RW'(REP_LIMIT)) w_rep_nxt = r_rep;
      else                         w_rep_nxt = r_rep + RW'(1);
    end
  end

  // Register the raw byte so sampling sees a stable value.
  always_ff @(posedge clk) begin
    r_raw_q <= raw;
  end

  // Free-running sample divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_strobe) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Repetition-count health test with sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep   <= '0;
      r_last  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_live) begin
        r_rep  <= w_rep_nxt;
        r_last <= r_raw_q;
      end
      if (w_trip) r_fault <= 1'b1;
    end
  end

  // Rotate-xor fold of samples into one byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_fold <= '0;
    end else if (w_live) begin
      if (w_fold_done) begin
        r_acc  <= '0;
        r_fold <= '0;
      end else begin
        r_acc  <= w_acc_nxt;
        r_fold <= r_fold + FW'(1);
      end
    end
  end

  // FIFO pointers; a health trip flushes the buffer.
  always_ff @(posedge clk) begin
    if (rst || w_trip) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + PW'(1);
      if (w_pop)   r_rd <= r_rd + PW'(1);
    end
  end

  // FIFO storage; contents are only meaningful below the write pointer.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[FIFO_AW-1:0]] <= w_acc_nxt;
  end

endmodule

// File: tb/tb_entropy_pool.sv
// tb_entropy_pool: scoreboard bench with a behavioural model for the
// default configuration plus a directed check of the minimal corner.
module tb_entropy_pool;

  localparam int DIV   = 16;
  localparam int FOLD  = 4;
  localparam int LIM   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_dat;
  logic       fault;

  logic       rst_c;
  logic [7:0] raw_c;
  logic       ready_c;
  logic       valid_c;
  logic [7:0] dat_c;
  logic       fault_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  entropy_pool u_dut (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_dat   (out_dat),
    .fault     (fault)
  );

  entropy_pool #(
    .SAMPLE_DIV (2),
    .FOLD       (1),
    .REP_LIMIT  (2),
    .FIFO_AW    (2)
  ) u_cor (
    .clk       (clk),
    .rst       (rst_c),
    .raw       (raw_c),
    .out_ready (ready_c),
    .out_valid (valid_c),
    .out_dat   (dat_c),
    .fault     (fault_c)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %02h want %02h t=%0t", nm, act, exp_v,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic samp(input logic [7:0] b, input int rdy_at);
    for (int j = 0; j < DIV; j++) begin
      raw       = b;
      out_ready = (j == rdy_at);
      tick();
    end
  endtask

  // Reference model: cycle index since reset, run length of equal
  // samples, running fold, and the queue of bytes the consumer should see.
  int         m_n;
  int         m_run;
  int         m_k;
  logic       m_fault;
  logic       m_has;
  logic [7:0] m_last;
  logic [7:0] m_acc;
  logic [7:0] m_rawq;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin : mdl
    logic [7:0] s;
    logic       trip;
    logic       psh;
    logic       pop;
    if (rst) begin
      m_n = 0; m_run = 0; m_k = 0;
      m_fault = 1'b0; m_has = 1'b0;
      m_last = 8'h00; m_acc = 8'h00;
      exp_q.delete();
    end else begin
      pop  = (exp_q.size() > 0) && !m_fault && out_ready;
      trip = 1'b0;
      psh  = 1'b0;
      if (!m_fault && (m_n % DIV) == DIV - 1) begin
        s     = m_rawq;
        m_run = (m_has && s == m_last) ? m_run + 1 : 1;
        m_has = 1'b1;
        m_last = s;
        trip  = (m_run == LIM);
        m_acc = {m_acc[6:0], m_acc[7]} ^ s;
        m_k++;
        psh = (m_k == FOLD);
      end
      if (trip) begin
        m_fault = 1'b1;
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (psh && exp_q.size() < DEPTH) exp_q.push_back(m_acc);
      end
      if (psh) begin
        m_acc = 8'h00;
        m_k = 0;
      end
      m_n++;
    end
    m_rawq = raw;
  end

  // Monitor: compare handshake, fault and popped data against the model.
  always @(negedge clk) begin : mon
    logic mv;
    if (!rst) begin
      mv = (exp_q.size() > 0) && !m_fault;
      chk("valid", {7'd0, out_valid}, {7'd0, mv});
      chk("fault", {7'd0, fault}, {7'd0, m_fault});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop got %02h want no byte t=%0t", out_dat,
                   $time);
        end else begin
          chk("data", out_dat, exp_q[0]);
        end
      end
    end
  end

  function automatic logic [7:0] vc(input int n);
    return 8'(n * 17 + 5);
  endfunction

  initial begin
    logic [7:0] v;
    logic [7:0] prev;
    rst = 1'b1; raw = 8'h00; out_ready = 1'b0;
    rst_c = 1'b1; raw_c = 8'h00; ready_c = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_fault", {7'd0, fault}, 8'd0);
    chk("rst_dat", out_dat, 8'h00);

    // Basic fold
    do_reset();
    samp(8'h01, -1); samp(8'h10, -1);
    samp(8'h80, -1); samp(8'h03, -1);
    @(negedge clk);
    chk("t1_valid64", {7'd0, out_valid}, 8'd1);
    chk("t1_dat64", out_dat, 8'h4A);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t1_popped", {7'd0, out_valid}, 8'd0);

    // Stuck source
    raw = 8'h5A;
    do_reset();
    repeat (64) tick();
    @(negedge clk);
    chk("t2_valid64", {7'd0, out_valid}, 8'd1);
    chk("t2_dat64", out_dat, 8'h55);
    repeat (63) tick();
    @(negedge clk);
    chk("t2_fault127", {7'd0, fault}, 8'd0);
    tick();
    @(negedge clk);
    chk("t2_fault128", {7'd0, fault}, 8'd1);
    chk("t2_valid128", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      raw = 8'($urandom);
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t2_stays", {7'd0, out_valid}, 8'd0);

    // Reset while faulted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_fault", {7'd0, fault}, 8'd0);
    chk("t5_valid", {7'd0, out_valid}, 8'd0);
    for (int i = 0; i < 63; i++) begin
      raw = 8'($urandom);
      tick();
    end
    @(negedge clk);
    chk("t5_valid63", {7'd0, out_valid}, 8'd0);
    tick();
    @(negedge clk);
    chk("t5_valid64", {7'd0, out_valid}, 8'd1);

    // Overflow: five folds, only four fit
    do_reset();
    prev = 8'h00;
    for (int i = 0; i < 5 * FOLD; i++) begin
      v = 8'($urandom);
      if (v == prev) v = v + 8'd1;
      prev = v;
      samp(v, -1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t3_drain", {7'd0, out_valid}, 8'd1);
      tick();
    end
    @(negedge clk);
    chk("t3_empty", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0;

    // Push and pop together while full
    do_reset();
    prev = 8'h00;
    for (int i = 0; i < 5 * FOLD; i++) begin
      v = 8'($urandom);
      if (v == prev) v = v + 8'd1;
      prev = v;
      samp(v, (i == 5 * FOLD - 1) ? DIV - 1 : -1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t4_drain", {7'd0, out_valid}, 8'd1);
      tick();
    end
    @(negedge clk);
    chk("t4_empty", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0;

    // Random traffic with a slow consumer and occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      raw       = 8'($urandom);
      out_ready = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    // Low-entropy source to exercise the health test repeatedly
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        raw       = 8'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 1) == 0);
        tick();
      end
    end

    // Corner: FOLD=1, SAMPLE_DIV=2, REP_LIMIT=2
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      raw_c = (n == 8) ? vc(6) : vc(n);
      @(negedge clk);
      if (n == 0 || n == 3)
        chk("c_idle", {7'd0, valid_c}, 8'd0);
      if (n == 2 || n == 4 || n == 6 || n == 8) begin
        chk("c_valid", {7'd0, valid_c}, 8'd1);
        chk("c_dat", dat_c, vc(n - 2));
      end
      if (n == 9)
        chk("c_fault9", {7'd0, fault_c}, 8'd0);
      if (n == 10) begin
        chk("c_fault10", {7'd0, fault_c}, 8'd1);
        chk("c_valid10", {7'd0, valid_c}, 8'd0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
